dmem_arbiter: RTL and testbench

Two-requester arbiter that shares the single-port data RAM between the pipeline memory stage (CPU port) and a debug/loader port (DBG port).
- CPU has default priority.
- DBG is guaranteed service after at most MAX_WAIT consecutive lost conflicts.
- Routes the synchronous-read response back to the owner and raises a stall to the pipeline when the CPU loses arbitration.
- Sits between the memory stage and data_ram.

---
 rtl/dmem_pkg.sv | 24 ++
 rtl/dmem_arb_starve_ctr.sv | 71 +++++++
 rtl/dmem_arbiter.sv | 127 ++++++++++++
 tb/tb_dmem_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and defaults for the data-memory arbiter slice.
// Holds the arbitration state and response-owner encodings plus a saturating increment.
package dmem_pkg;

   typedef enum logic {
      CPU_PRI = 1'b0,
      DBG_PRI = 1'b1
   } arb_state_t;

   typedef enum logic [1:0] {
      OWN_NONE = 2'b00,
      OWN_CPU  = 2'b01,
      OWN_DBG  = 2'b10
   } rsp_owner_t;

   localparam int DEF_AW       = 32;
   localparam int DEF_DW       = 32;
   localparam int DEF_MAX_WAIT = 4;

   function automatic logic [3:0] sat_inc4(input logic [3:0] v);
      return (v == 4'hF) ? v : v + 4'd1;
   endfunction

endpackage

// File: rtl/dmem_arb_starve_ctr.sv
// Starvation guard: counts conflicts DBG lost and forces one DBG grant at MAX_WAIT.
// Ports: clk, rst, conflict, dbg_grant, dbg_valid in; dbg_pri out; forced out with DMEM_ARB_STATS_EN.
module dmem_arb_starve_ctr
   import dmem_pkg::*;
#(
   parameter int MAX_WAIT = DEF_MAX_WAIT
)(
   input  logic clk,
   input  logic rst,
   input  logic conflict,
   input  logic dbg_grant,
   input  logic dbg_valid,
`ifdef DMEM_ARB_STATS_EN
   output logic forced,
`endif
   output logic dbg_pri
);

   localparam logic [3:0] MW = 4'(MAX_WAIT);

   arb_state_t state, state_n;
   logic [3:0] wait_cnt, wait_n;
   logic       go_dbg;

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= CPU_PRI;
         wait_cnt <= 4'd0;
      end else begin
         state    <= state_n;
         wait_cnt <= wait_n;
      end
   end

   always_comb begin
      state_n = state;
      wait_n  = wait_cnt;
      go_dbg  = 1'b0;
      unique case (state)
         CPU_PRI: begin
            if (conflict) begin
               wait_n = sat_inc4(wait_cnt);
               if (wait_n >= MW) begin
                  state_n = DBG_PRI;
                  go_dbg  = 1'b1;
               end
            end else if (dbg_grant) begin
               wait_n = 4'd0;
            end
         end
         DBG_PRI: begin
            // leave on the forced grant, or if DBG gave up first
            if (dbg_grant || !dbg_valid) begin
               state_n = CPU_PRI;
               wait_n  = 4'd0;
            end
         end
         default: begin
            state_n = CPU_PRI;
            wait_n  = 4'd0;
         end
      endcase
   end

   assign dbg_pri = (state == DBG_PRI);

`ifdef DMEM_ARB_STATS_EN
   assign forced = go_dbg;
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data RAM between the CPU memory stage and the DBG/loader port.
// Ports: cpu_* and dbg_* requesters, ram_* RAM side; conflict_cnt/forced_cnt with DMEM_ARB_STATS_EN.
module dmem_arbiter
   import dmem_pkg::*;
#(
   parameter int AW       = DEF_AW,
   parameter int DW       = DEF_DW,
   parameter int MAX_WAIT = DEF_MAX_WAIT
)(
   input  logic          clk,
   input  logic          rst,
   input  logic          cpu_req,
   input  logic          cpu_we,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_wdata,
   output logic          cpu_stall,
   output logic          cpu_rvalid,
   output logic [DW-1:0] cpu_rdata,
   input  logic          dbg_valid,
   output logic          dbg_ready,
   input  logic          dbg_we,
   input  logic [AW-1:0] dbg_addr,
   input  logic [DW-1:0] dbg_wdata,
   output logic          dbg_rvalid,
   output logic [DW-1:0] dbg_rdata,
   output logic          ram_we,
   output logic [AW-1:0] ram_addr,
   output logic [DW-1:0] ram_wdata,
`ifdef DMEM_ARB_STATS_EN
   output logic [15:0]   conflict_cnt,
   output logic [15:0]   forced_cnt,
`endif
   input  logic [DW-1:0] ram_rdata
);

   logic       dbg_pri;
   logic       gnt_cpu, gnt_dbg, conflict;
   rsp_owner_t rsp_owner;
   logic [DW-1:0] cpu_hold, dbg_hold;

   // CPU wins unless DBG has been starved long enough
   assign gnt_cpu   = !rst && cpu_req && !(dbg_valid && dbg_pri);
   assign gnt_dbg   = !rst && dbg_valid && !gnt_cpu;
   assign conflict  = gnt_cpu && dbg_valid;
   assign cpu_stall = !rst && cpu_req && !gnt_cpu;
   assign dbg_ready = gnt_dbg;

`ifdef DMEM_ARB_STATS_EN
   logic forced;
`endif

   dmem_arb_starve_ctr #(
      .MAX_WAIT (MAX_WAIT)
   ) u_starve (
      .clk       (clk),
      .rst       (rst),
      .conflict  (conflict),
      .dbg_grant (gnt_dbg),
      .dbg_valid (dbg_valid),
`ifdef DMEM_ARB_STATS_EN
      .forced    (forced),
`endif
      .dbg_pri   (dbg_pri)
   );

   always_comb begin
      ram_we    = 1'b0;
      ram_addr  = '0;
      ram_wdata = '0;
      unique case (1'b1)
         gnt_cpu: begin
            ram_we    = cpu_we;
            ram_addr  = cpu_addr;
            ram_wdata = cpu_wdata;
         end
         gnt_dbg: begin
            ram_we    = dbg_we;
            ram_addr  = dbg_addr;
            ram_wdata = dbg_wdata;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst)
         rsp_owner <= OWN_NONE;
      else if (gnt_cpu && !cpu_we)
         rsp_owner <= OWN_CPU;
      else if (gnt_dbg && !dbg_we)
         rsp_owner <= OWN_DBG;
      else
         rsp_owner <= OWN_NONE;
   end

   // gating with rst drops a response whose read was granted just before reset
   assign cpu_rvalid = !rst && (rsp_owner == OWN_CPU);
   assign dbg_rvalid = !rst && (rsp_owner == OWN_DBG);

   always_ff @(posedge clk) begin
      if (rst) begin
         cpu_hold <= '0;
         dbg_hold <= '0;
      end else begin
         if (cpu_rvalid) cpu_hold <= ram_rdata;
         if (dbg_rvalid) dbg_hold <= ram_rdata;
      end
   end

   assign cpu_rdata = cpu_rvalid ? ram_rdata : cpu_hold;
   assign dbg_rdata = dbg_rvalid ? ram_rdata : dbg_hold;

`ifdef DMEM_ARB_STATS_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         conflict_cnt <= 16'd0;
         forced_cnt   <= 16'd0;
      end else begin
         if (conflict && conflict_cnt != 16'hFFFF)
            conflict_cnt <= conflict_cnt + 16'd1;
         if (forced && forced_cnt != 16'hFFFF)
            forced_cnt <= forced_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed vector table, corner sequences, random vs model.
// Stats checks are compiled when DMEM_ARB_STATS_EN is defined.
module tb_dmem_arbiter;

   localparam int MW = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        cpu_req, cpu_we;
   logic [31:0] cpu_addr, cpu_wdata;
   logic        cpu_stall, cpu_rvalid;
   logic [31:0] cpu_rdata;
   logic        dbg_valid, dbg_ready, dbg_we;
   logic [31:0] dbg_addr, dbg_wdata;
   logic        dbg_rvalid;
   logic [31:0] dbg_rdata;
   logic        ram_we;
   logic [31:0] ram_addr, ram_wdata, ram_rdata;
`ifdef DMEM_ARB_STATS_EN
   logic [15:0] conflict_cnt, forced_cnt;
`endif

   dmem_arbiter #(.AW(32), .DW(32), .MAX_WAIT(MW)) dut (
      .clk(clk), .rst(rst),
      .cpu_req(cpu_req), .cpu_we(cpu_we),
      .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid),
      .cpu_rdata(cpu_rdata),
      .dbg_valid(dbg_valid), .dbg_ready(dbg_ready),
      .dbg_we(dbg_we), .dbg_addr(dbg_addr),
      .dbg_wdata(dbg_wdata), .dbg_rvalid(dbg_rvalid),
      .dbg_rdata(dbg_rdata),
      .ram_we(ram_we), .ram_addr(ram_addr),
      .ram_wdata(ram_wdata),
`ifdef DMEM_ARB_STATS_EN
      .conflict_cnt(conflict_cnt), .forced_cnt(forced_cnt),
`endif
      .ram_rdata(ram_rdata)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] init_word(input int i);
      if (i == 16) return 32'hDEADBEEF;
      return 32'h1000_0000 + 32'(i) * 32'h0101_0101;
   endfunction

   // synchronous-read RAM, reloaded while rst is high
   logic [31:0] ram [64];
   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 64; i++) ram[i] <= init_word(i);
      end else if (ram_we) begin
         ram[ram_addr[5:0]] <= ram_wdata;
      end
      ram_rdata <= ram[ram_addr[5:0]];
   end

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d actual=%h expected=%h", nm, cyc, act, exp);
      end
   endtask

   // reference model: DBG losses, expected memory, pending response
   int          losses = 0;
   int          conf_n = 0;
   int          forced_n = 0;
   logic [31:0] shadow [64];
   int          pend = 0;
   logic [31:0] pend_data = 0;
   logic [31:0] cpu_last = 0, dbg_last = 0;
   bit          cpu_known = 0, dbg_known = 0;
   bit          m_gc = 0, m_gd = 0;

   task automatic model_check();
      logic        e_we;
      logic [31:0] e_ad, e_wd;
      bit          crv, drv;
      if (rst) begin
         m_gc = 0;
         m_gd = 0;
      end else begin
         m_gc = cpu_req && !(dbg_valid && losses >= MW);
         m_gd = dbg_valid && !m_gc;
      end
      e_we = 0; e_ad = 0; e_wd = 0;
      if (m_gc) begin e_we = cpu_we; e_ad = cpu_addr; e_wd = cpu_wdata; end
      if (m_gd) begin e_we = dbg_we; e_ad = dbg_addr; e_wd = dbg_wdata; end
      chk("m_stall", {31'b0, cpu_stall}, {31'b0, !rst && cpu_req && !m_gc});
      chk("m_ready", {31'b0, dbg_ready}, {31'b0, m_gd});
      chk("m_ram_we", {31'b0, ram_we}, {31'b0, e_we});
      chk("m_ram_addr", ram_addr, e_ad);
      chk("m_ram_wdata", ram_wdata, e_wd);
      crv = !rst && pend == 1;
      drv = !rst && pend == 2;
      chk("m_cpu_rvalid", {31'b0, cpu_rvalid}, {31'b0, crv});
      chk("m_dbg_rvalid", {31'b0, dbg_rvalid}, {31'b0, drv});
      if (crv) chk("m_cpu_rdata", cpu_rdata, pend_data);
      else if (cpu_known && !rst) chk("m_cpu_hold", cpu_rdata, cpu_last);
      if (drv) chk("m_dbg_rdata", dbg_rdata, pend_data);
      else if (dbg_known && !rst) chk("m_dbg_hold", dbg_rdata, dbg_last);
`ifdef DMEM_ARB_STATS_EN
      chk("m_conflict_cnt", {16'b0, conflict_cnt}, 32'(conf_n));
      chk("m_forced_cnt", {16'b0, forced_cnt}, 32'(forced_n));
`endif
   endtask

   task automatic model_update();
      if (rst) begin
         losses = 0; pend = 0; conf_n = 0; forced_n = 0;
         cpu_known = 0; dbg_known = 0;
         for (int i = 0; i < 64; i++) shadow[i] = init_word(i);
         return;
      end
      if (pend == 1) begin cpu_last = pend_data; cpu_known = 1; end
      if (pend == 2) begin dbg_last = pend_data; dbg_known = 1; end
      pend = 0;
      if (m_gc && !cpu_we) begin pend = 1; pend_data = shadow[cpu_addr[5:0]]; end
      if (m_gd && !dbg_we) begin pend = 2; pend_data = shadow[dbg_addr[5:0]]; end
      if (m_gc && cpu_we) shadow[cpu_addr[5:0]] = cpu_wdata;
      if (m_gd && dbg_we) shadow[dbg_addr[5:0]] = dbg_wdata;
      if (m_gc && dbg_valid) begin
         if (losses < 15) losses++;
         if (conf_n < 65535) conf_n++;
         if (losses == MW && forced_n < 65535) forced_n++;
      end else if (m_gd) begin
         losses = 0;
      end else if (!dbg_valid && losses >= MW) begin
         losses = 0;
      end
   endtask

   task automatic tick();
      @(negedge clk);
      model_check();
      @(posedge clk);
      model_update();
      cyc++;
      #1;
   endtask

   task automatic set_in(input logic cr, cw, input logic [31:0] ca, cd,
                         input logic dv, dw, input logic [31:0] da, dd);
      cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
      dbg_valid = dv; dbg_we = dw; dbg_addr = da; dbg_wdata = dd;
   endtask

   typedef struct {
      logic cr, cw; logic [31:0] ca, cd;
      logic dv, dw; logic [31:0] da, dd;
      logic st, rdy, we; logic [31:0] ad, wd;
      logic crv; logic [31:0] crd;
      logic drv; logic [31:0] drd;
   } vec_t;

   function automatic vec_t mk(
      input logic cr, cw, input logic [31:0] ca, cd,
      input logic dv, dw, input logic [31:0] da, dd,
      input logic st, rdy, we, input logic [31:0] ad, wd,
      input logic crv, input logic [31:0] crd,
      input logic drv, input logic [31:0] drd);
      vec_t v;
      v.cr = cr; v.cw = cw; v.ca = ca; v.cd = cd;
      v.dv = dv; v.dw = dw; v.da = da; v.dd = dd;
      v.st = st; v.rdy = rdy; v.we = we; v.ad = ad; v.wd = wd;
      v.crv = crv; v.crd = crd; v.drv = drv; v.drd = drd;
      return v;
   endfunction

   vec_t tbl [18];

   initial begin
      logic [31:0] m4, m8;
      m4 = init_word(4);
      m8 = init_word(8);
      tbl[0]  = mk(1,0,32'h10,0, 0,0,0,0, 0,0,0,32'h10,0, 0,0, 0,0);
      tbl[1]  = mk(0,0,0,0, 0,0,0,0, 0,0,0,0,0, 1,32'hDEADBEEF, 0,0);
      tbl[2]  = mk(0,0,0,0, 1,1,32'h20,32'h12345678,
                   0,1,1,32'h20,32'h12345678, 0,0, 0,0);
      tbl[3]  = mk(0,0,0,0, 0,0,0,0, 0,0,0,0,0, 0,0, 0,0);
      for (int i = 4; i < 8; i++)
         tbl[i] = mk(1,0,4,0, 1,0,8,0, 0,0,0,4,0, i != 4,m4, 0,0);
      tbl[8]  = mk(1,0,4,0, 1,0,8,0, 1,1,0,8,0, 1,m4, 0,0);
      tbl[9]  = mk(1,0,4,0, 0,0,0,0, 0,0,0,4,0, 0,0, 1,m8);
      tbl[10] = mk(0,0,0,0, 1,0,8,0, 0,1,0,8,0, 1,m4, 0,0);
      tbl[11] = mk(0,0,0,0, 0,0,0,0, 0,0,0,0,0, 0,0, 1,m8);
      for (int i = 12; i < 16; i++)
         tbl[i] = mk(1,0,4,0, 1,0,8,0, 0,0,0,4,0, i != 12,m4, 0,0);
      tbl[16] = mk(1,0,4,0, 1,0,8,0, 1,1,0,8,0, 1,m4, 0,0);
      tbl[17] = mk(0,0,0,0, 0,0,0,0, 0,0,0,0,0, 0,0, 1,m8);

      rst = 1'b1;
      set_in(1,1,5,32'h55,1,1,6,32'h66);
      @(posedge clk); #1;
      @(negedge clk);
      chk("rst_stall", {31'b0, cpu_stall}, 0);
      chk("rst_ready", {31'b0, dbg_ready}, 0);
      chk("rst_ram_we", {31'b0, ram_we}, 0);
      chk("rst_cpu_rvalid", {31'b0, cpu_rvalid}, 0);
      chk("rst_dbg_rvalid", {31'b0, dbg_rvalid}, 0);
      model_check();
      @(posedge clk); model_update(); cyc++; #1;
      rst = 1'b0;
      set_in(0,0,0,0,0,0,0,0);

      for (int i = 0; i < 18; i++) begin
         set_in(tbl[i].cr, tbl[i].cw, tbl[i].ca, tbl[i].cd,
                tbl[i].dv, tbl[i].dw, tbl[i].da, tbl[i].dd);
         @(negedge clk);
         chk($sformatf("v%0d_stall", i), {31'b0, cpu_stall}, {31'b0, tbl[i].st});
         chk($sformatf("v%0d_ready", i), {31'b0, dbg_ready}, {31'b0, tbl[i].rdy});
         chk($sformatf("v%0d_we", i), {31'b0, ram_we}, {31'b0, tbl[i].we});
         chk($sformatf("v%0d_addr", i), ram_addr, tbl[i].ad);
         chk($sformatf("v%0d_wdata", i), ram_wdata, tbl[i].wd);
         chk($sformatf("v%0d_crv", i), {31'b0, cpu_rvalid}, {31'b0, tbl[i].crv});
         chk($sformatf("v%0d_drv", i), {31'b0, dbg_rvalid}, {31'b0, tbl[i].drv});
         if (tbl[i].crv) chk($sformatf("v%0d_crd", i), cpu_rdata, tbl[i].crd);
         if (tbl[i].drv) chk($sformatf("v%0d_drd", i), dbg_rdata, tbl[i].drd);
         model_check();
         @(posedge clk); model_update(); cyc++; #1;
      end

      // DBG read granted, reset in the response cycle
      set_in(0,0,0,0, 1,0,8,0);
      tick();
      rst = 1'b1;
      set_in(0,0,0,0,0,0,0,0);
      @(negedge clk);
      chk("rstmid_dbg_rvalid", {31'b0, dbg_rvalid}, 0);
      model_check();
      @(posedge clk); model_update(); cyc++; #1;
      rst = 1'b0;

      // reach forced priority, then reset: must come back CPU-first
      set_in(1,0,3,0, 1,0,9,0);
      for (int i = 0; i < MW; i++) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_stall", {31'b0, cpu_stall}, 0);
      chk("post_rst_ready", {31'b0, dbg_ready}, 0);
      model_check();
      @(posedge clk); model_update(); cyc++; #1;
      for (int i = 0; i < MW; i++) tick();

      // DBG withdraws while it holds priority
      set_in(0,0,0,0,0,0,0,0);
      tick();
      set_in(1,0,3,0, 1,0,9,0);
      for (int i = 0; i < MW; i++) tick();
      set_in(1,0,3,0, 0,0,0,0);
      tick();
      set_in(1,0,3,0, 1,0,9,0);
      @(negedge clk);
      chk("drop_cpu_first", {31'b0, cpu_stall}, 0);
      model_check();
      @(posedge clk); model_update(); cyc++; #1;

`ifdef DMEM_ARB_STATS_EN
      rst = 1'b1;
      set_in(0,0,0,0,0,0,0,0);
      tick();
      rst = 1'b0;
      set_in(1,0,3,0, 1,0,9,0);
      for (int i = 0; i < 10; i++) tick();
      set_in(0,0,0,0,0,0,0,0);
      @(negedge clk);
      chk("stats_forced", {16'b0, forced_cnt}, 2);
      chk("stats_conflict", {16'b0, conflict_cnt}, 8);
      model_check();
      @(posedge clk); model_update(); cyc++; #1;
`endif

      for (int n = 0; n < 1500; n++) begin
         if (!(cpu_req && !m_gc)) begin
            cpu_req   = ($urandom_range(0, 3) != 0);
            cpu_we    = 1'($urandom_range(0, 1));
            cpu_addr  = $urandom_range(0, 63);
            cpu_wdata = $urandom;
         end
         if (!(dbg_valid && !m_gd) || $urandom_range(0, 15) == 0) begin
            dbg_valid = 1'($urandom_range(0, 1));
            dbg_we    = 1'($urandom_range(0, 1));
            dbg_addr  = $urandom_range(0, 63);
            dbg_wdata = $urandom;
         end
         rst = ($urandom_range(0, 199) == 0);
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
